// File: rtl/approx_prod_accumulator.sv
// Accumulates a stream of approximate products into per-group sums.
// Product bits below DROP_LSB are known zero, so the accumulator holds only
// the upper bits and re-appends the zero LSBs when a result is presented.
// Completed sums sit in a registered valid/ready output stage.
module approx_prod_accumulator #(
    parameter int PROD_W   = 24,
    parameter int DROP_LSB = 9,
    parameter int ACC_W    = 32,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat,
    output logic              out_lsb_err
);

    localparam int AW = ACC_W - DROP_LSB;   // stored accumulator width
    localparam int TW = PROD_W - DROP_LSB;  // stored term width

    typedef enum logic {ACCUM, FULL} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sat, sat_nxt;
    logic             lsb_err, lsb_err_nxt;
    logic             accept;
    logic             accept_last;

    // Saturating add of one term; MSB of the result flags overflow.
    function automatic logic [AW:0] acc_add(input logic [AW-1:0] a, input logic [TW-1:0] t);
        logic [AW:0] s;
        s = {1'b0, a} + {{(AW + 1 - TW){1'b0}}, t};
        if (s[AW]) begin
            s = {1'b1, {AW{1'b1}}};
        end
        return s;
    endfunction

    // Saturating term counter increment; MSB of the result flags saturation.
    function automatic logic [CNT_W:0] cnt_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W:0] r;
        if (c == {CNT_W{1'b1}}) begin
            r = {1'b1, c};
        end else begin
            r = {1'b0, c + {{(CNT_W - 1){1'b0}}, 1'b1}};
        end
        return r;
    endfunction

    assign out_valid   = (state == FULL);
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign accept_last = accept && in_last;

    // Next accumulator, counter and sticky flags including the current beat.
    always_comb begin
        logic [AW:0]    add_r;
        logic [CNT_W:0] inc_r;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        sat_nxt     = sat;
        lsb_err_nxt = lsb_err;
        add_r       = '0;
        inc_r       = '0;
        if (accept) begin
            add_r       = acc_add(acc, in_prod[PROD_W-1:DROP_LSB]);
            inc_r       = cnt_inc(cnt);
            acc_nxt     = add_r[AW-1:0];
            cnt_nxt     = inc_r[CNT_W-1:0];
            sat_nxt     = sat || add_r[AW] || inc_r[CNT_W];
            lsb_err_nxt = lsb_err || (in_prod[DROP_LSB-1:0] != '0);
        end
    end

    // Output handshake FSM: FULL while a completed sum is waiting.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (accept_last) state_nxt = FULL;
            FULL:  if (out_ready && !accept_last) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Running group state; cleared when the last beat hands off to the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
            lsb_err <= 1'b0;
        end else if (accept_last) begin
            acc     <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
            lsb_err <= 1'b0;
        end else if (accept) begin
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            sat     <= sat_nxt;
            lsb_err <= lsb_err_nxt;
        end
    end

    // Result registers load only on an accepted last beat and otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum     <= '0;
            out_count   <= '0;
            out_sat     <= 1'b0;
            out_lsb_err <= 1'b0;
        end else if (accept_last) begin
            out_sum     <= {acc_nxt, {DROP_LSB{1'b0}}};
            out_count   <= cnt_nxt;
            out_sat     <= sat_nxt;
            out_lsb_err <= lsb_err_nxt;
        end
    end

endmodule

// File: tb/tb_approx_prod_accumulator.sv
// Directed bench for approx_prod_accumulator with a scoreboard of expected sums.
// Instance a uses default widths; instance b uses ACC_W=26 to reach sum overflow.
module tb_approx_prod_accumulator;

    localparam int PW = 24;
    localparam int DL = 9;
    localparam int CW = 8;

    typedef struct packed {
        logic [31:0] sum;
        logic [7:0]  cnt;
        logic        sat;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    in_valid = '0;
    logic [1:0]    in_last = '0;
    logic [1:0]    out_ready = '0;
    logic [PW-1:0] in_prod [2];

    logic          rdy_a, vld_a, sat_a, err_a;
    logic [31:0]   sum_a;
    logic [CW-1:0] cnt_a;
    logic          rdy_b, vld_b, sat_b, err_b;
    logic [25:0]   sum_b;
    logic [CW-1:0] cnt_b;

    int compared = 0;
    int mismatched = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    longint unsigned m_acc [2];
    int              m_cnt [2];
    bit              m_sat [2];
    bit              m_err [2];
    int              m_aw  [2] = '{23, 17};

    always #5 clk = ~clk;

    approx_prod_accumulator #(.PROD_W(PW), .DROP_LSB(DL), .ACC_W(32), .CNT_W(CW)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(rdy_a), .in_prod(in_prod[0]), .in_last(in_last[0]),
        .out_valid(vld_a), .out_ready(out_ready[0]), .out_sum(sum_a), .out_count(cnt_a),
        .out_sat(sat_a), .out_lsb_err(err_a)
    );

    approx_prod_accumulator #(.PROD_W(PW), .DROP_LSB(DL), .ACC_W(26), .CNT_W(CW)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(rdy_b), .in_prod(in_prod[1]), .in_last(in_last[1]),
        .out_valid(vld_b), .out_ready(out_ready[1]), .out_sum(sum_b), .out_count(cnt_b),
        .out_sat(sat_b), .out_lsb_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int s);
        m_acc[s] = 0;
        m_cnt[s] = 0;
        m_sat[s] = 1'b0;
        m_err[s] = 1'b0;
    endtask

    // Reference behaviour of one accepted beat; pushes the expected result on last.
    task automatic model_beat(input int s, input logic [PW-1:0] p, input logic l);
        longint unsigned mx;
        longint unsigned t;
        exp_t e;
        mx = (64'd1 << m_aw[s]) - 1;
        t  = 64'(p) / 512;
        if (m_acc[s] + t > mx) begin
            m_acc[s] = mx;
            m_sat[s] = 1'b1;
        end else begin
            m_acc[s] = m_acc[s] + t;
        end
        if (m_cnt[s] == 255) m_sat[s] = 1'b1;
        else m_cnt[s] = m_cnt[s] + 1;
        if ((p % 512) != 0) m_err[s] = 1'b1;
        if (l) begin
            e.sum = 32'(m_acc[s] * 512);
            e.cnt = 8'(m_cnt[s]);
            e.sat = m_sat[s];
            e.err = m_err[s];
            if (s == 0) q_a.push_back(e);
            else q_b.push_back(e);
            model_clear(s);
        end
    endtask

    // Drive one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input int s, input logic [PW-1:0] p, input logic l);
        int  n;
        bit  done;
        logic r;
        in_valid[s] = 1'b1;
        in_prod[s]  = p;
        in_last[s]  = l;
        n = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            r = (s == 0) ? rdy_a : rdy_b;
            if (r) begin
                model_beat(s, p, l);
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                n++;
                if (n >= 200) begin
                    compared++;
                    mismatched++;
                    $error("FAIL send_timeout: observed no in_ready after %0d cycles expected acceptance", n);
                    done = 1;
                end
            end
        end
        in_valid[s] = 1'b0;
        in_last[s]  = 1'b0;
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_valid"}, 32'(vld_a), 32'd0);
        chk({tag, "_sum"},   sum_a,      32'd0);
        chk({tag, "_count"}, 32'(cnt_a), 32'd0);
        chk({tag, "_sat"},   32'(sat_a), 32'd0);
        chk({tag, "_err"},   32'(err_a), 32'd0);
    endtask

    // Scoreboard: compare each result as it is handed over.
    always @(negedge clk) begin
        if (rst_n && vld_a && out_ready[0]) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_result", 32'd1, 32'd0);
            end else begin
                e_a = q_a.pop_front();
                chk("a_sum",   sum_a,      e_a.sum);
                chk("a_count", 32'(cnt_a), 32'(e_a.cnt));
                chk("a_sat",   32'(sat_a), 32'(e_a.sat));
                chk("a_err",   32'(err_a), 32'(e_a.err));
            end
        end
        if (rst_n && vld_b && out_ready[1]) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_result", 32'd1, 32'd0);
            end else begin
                e_b = q_b.pop_front();
                chk("b_sum",   32'(sum_b), e_b.sum);
                chk("b_count", 32'(cnt_b), 32'(e_b.cnt));
                chk("b_sat",   32'(sat_b), 32'(e_b.sat));
                chk("b_err",   32'(err_b), 32'(e_b.err));
            end
        end
    end

    initial begin
        in_prod[0] = '0;
        in_prod[1] = '0;
        model_clear(0);
        model_clear(1);

        // Reset state
        #1;
        chk_zero_a("reset");
        chk("reset_in_ready", 32'(rdy_a), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: three beats, immediate pop
        out_ready = 2'b11;
        send(0, 24'h000200, 1'b0);
        send(0, 24'h000400, 1'b0);
        chk("t1_no_early_valid", 32'(vld_a), 32'd0);
        send(0, 24'h7FFE00, 1'b1);
        @(negedge clk);
        chk("t1_latency_valid", 32'(vld_a), 32'd1);
        chk("t1_sum",   sum_a,      32'h00800400);
        chk("t1_count", 32'(cnt_a), 32'd3);
        chk("t1_flags", {30'd0, sat_a, err_a}, 32'd0);
        @(negedge clk);
        chk("t1_pop_valid", 32'(vld_a), 32'd0);
        chk("t1_pop_sum_kept", sum_a, 32'h00800400);

        // T2: sum saturation on the narrow instance, then a clean group
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send(1, 24'hFFFE00, i == 4);
        @(negedge clk);
        chk("t2_sat_sum",   32'(sum_b), 32'h03FFFE00);
        chk("t2_sat_flag",  32'(sat_b), 32'd1);
        chk("t2_sat_count", 32'(cnt_b), 32'd5);
        @(posedge clk);
        #1;
        send(1, 24'h000200, 1'b1);
        @(negedge clk);
        chk("t2_next_sum", 32'(sum_b), 32'h200);
        chk("t2_next_sat", 32'(sat_b), 32'd0);

        // T3: held result and stalled beat
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        send(0, 24'h000400, 1'b1);
        in_valid[0] = 1'b1;
        in_prod[0]  = 24'h000600;
        in_last[0]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_in_ready", 32'(rdy_a), 32'd0);
            chk("t3_hold_valid",     32'(vld_a), 32'd1);
            chk("t3_hold_sum",       sum_a,      32'h400);
            chk("t3_hold_count",     32'(cnt_a), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        send(0, 24'h000600, 1'b1);
        @(negedge clk);
        chk("t3_no_gap_valid", 32'(vld_a), 32'd1);
        chk("t3_second_sum",   sum_a,      32'h600);

        // T4: back-to-back single-beat groups
        @(posedge clk);
        #1;
        for (int i = 1; i <= 6; i++) begin
            send(0, PW'(i * 24'h200), 1'b1);
            chk("t4_in_ready",  32'(rdy_a), 32'd1);
            chk("t4_out_valid", 32'(vld_a), 32'd1);
        end

        // T5: nonzero dropped bits
        send(0, 24'h000201, 1'b1);
        @(negedge clk);
        chk("t5_sum", sum_a, 32'h200);
        chk("t5_err", 32'(err_a), 32'd1);
        @(posedge clk);
        #1;
        send(0, 24'h000400, 1'b1);
        @(negedge clk);
        chk("t5_clean_err", 32'(err_a), 32'd0);

        // Counter saturation: 300 terms
        @(posedge clk);
        #1;
        for (int i = 0; i < 300; i++) send(0, 24'h000200, i == 299);
        @(negedge clk);
        chk("cnt_sat_count", 32'(cnt_a), 32'd255);
        chk("cnt_sat_flag",  32'(sat_a), 32'd1);
        chk("cnt_sat_sum",   sum_a,      32'h00025800);

        // T6a: async reset in the middle of a group
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        send(0, 24'h000800, 1'b0);
        send(0, 24'h000800, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_a("t6a_reset");
        model_clear(0);
        model_clear(1);
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // T6b: async reset while a result is held
        @(posedge clk);
        #1;
        send(0, 24'h000400, 1'b1);
        chk("t6b_held_valid", 32'(vld_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_a("t6b_reset");
        model_clear(0);
        model_clear(1);
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Post-reset group: no remnant of the discarded partial sum
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        send(0, 24'h000200, 1'b1);
        @(negedge clk);
        chk("t6_post_sum",   sum_a,      32'h200);
        chk("t6_post_count", 32'(cnt_a), 32'd1);

        // Drain and confirm every expected result was seen
        for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
        chk("drain_q_a", 32'(q_a.size()), 32'd0);
        chk("drain_q_b", 32'(q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
